// File: rtl/udivider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock.
// The start/busy/done handshake gives a fixed latency, and every output is registered.
module udivider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;
    logic             dz_wait;
    logic [WIDTH:0]   trial;

    always_comb begin
        trial = {r_reg[WIDTH-1:0], q_sr[WIDTH-1]} - {1'b0, d_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_sr    <= '0;
            d_reg   <= '0;
            a_reg   <= '0;
            r_reg   <= '0;
            count   <= '0;
            dz_wait <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_sr  <= dividend;
                        a_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        count <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                        // A zero divisor skips the iterations.
                        // It then spends two cycles in FINISH, which makes start-to-done two cycles.
                        if (divisor == '0) begin
                            state   <= FINISH;
                            dz_wait <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        r_reg <= trial;
                        q_sr  <= {q_sr[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= {r_reg[WIDTH-1:0], q_sr[WIDTH-1]};
                        q_sr  <= {q_sr[WIDTH-2:0], 1'b0};
                    end
                    if (count == '0) state <= FINISH;
                    else             count <= count - 1'b1;
                end
                FINISH: begin
                    if (dz_wait) begin
                        dz_wait <= 1'b0;
                    end else begin
                        if (d_reg == '0) begin
                            quot <= '1;
                            rem  <= a_reg;
                            dbz  <= 1'b1;
                        end else begin
                            quot <= q_sr;
                            rem  <= r_reg[WIDTH-1:0];
                            dbz  <= 1'b0;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udivider.sv
// Randomized self-checking bench for udivider at WIDTH=32 and WIDTH=8.
// Results are checked against plain-arithmetic division and the division invariant.
module tb_udivider;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  dividend, divisor, quot, rem;
    logic          busy, done, dbz;
    logic          start8;
    logic [W8-1:0] dividend8, divisor8, quot8, rem8;
    logic          busy8, done8, dbz8;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    udivider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .dbz(dbz)
    );

    udivider #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quot(quot8), .rem(rem8), .dbz(dbz8)
    );

    always @(posedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done32(output int cnt);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic op32(input logic [W-1:0] a, input logic [W-1:0] b);
        int cnt;
        logic [W-1:0] eq, er;
        cnt = 0;
        while (busy && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("idle_before_start", busy, 0);
        start = 1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 0; dividend = $urandom; divisor = $urandom;
        chk("busy_after_accept", busy, 1);
        chk("done_low_after_accept", done, 0);
        wait_done32(cnt);
        chk("latency", cnt, (b == 0) ? 2 : W + 1);
        chk("busy_low_at_done", busy, 0);
        eq = (b == 0) ? '1 : a / b;
        er = (b == 0) ? a : a % b;
        chk("quot", quot, eq);
        chk("rem", rem, er);
        chk("dbz", dbz, b == 0);
        if (b != 0) begin
            chk("invariant", 64'(quot) * 64'(b) + 64'(rem), 64'(a));
            chk("rem_lt_divisor", rem < b, 1);
        end
    endtask

    task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        int cnt;
        logic [W8-1:0] eq, er;
        start8 = 1; dividend8 = a; divisor8 = b;
        @(posedge clk); #1;
        start8 = 0; dividend8 = W8'($urandom); divisor8 = W8'($urandom);
        chk("w8_busy_after_accept", busy8, 1);
        cnt = 0;
        while (!done8 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("w8_latency", cnt, (b == 0) ? 2 : W8 + 1);
        eq = (b == 0) ? '1 : a / b;
        er = (b == 0) ? a : a % b;
        chk("w8_quot", quot8, eq);
        chk("w8_rem", rem8, er);
        chk("w8_dbz", dbz8, b == 0);
        if (b != 0) chk("w8_invariant", 32'(quot8) * 32'(b) + 32'(rem8), 32'(a));
    endtask

    function automatic logic [W-1:0] rand_divisor();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel < 4)  return W'($urandom_range(1, 255));
        return W'($urandom);
    endfunction

    initial begin
        int cnt, d0;
        logic [W-1:0] held_q;
        rst_n = 0; start = 0; dividend = '0; divisor = '0;
        start8 = 0; dividend8 = '0; divisor8 = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_w8_busy", busy8, 0);
        @(posedge clk); #1;
        rst_n = 1;

        op32(100, 7);
        op32(32'hFFFF_FFFF, 1);
        op32(5, 9);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op32(1234, 0);
        op32(10, 3);

        // Start held through busy with new operands; only the first operands count until done.
        @(posedge clk); #1;
        d0 = n_done;
        start = 1; dividend = 50; divisor = 5;
        @(posedge clk); #1;
        dividend = 77; divisor = 10;
        wait_done32(cnt);
        chk("held_first_latency", cnt, W + 1);
        chk("held_first_quot", quot, 10);
        chk("held_first_rem", rem, 0);
        @(posedge clk); #1;
        start = 0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_pulse_width", done, 0);
        wait_done32(cnt);
        chk("b2b_latency", cnt, W + 1);
        chk("b2b_quot", quot, 7);
        chk("b2b_rem", rem, 7);
        held_q = quot;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count_held_start", n_done - d0, 2);
        chk("quot_holds", quot, held_q);

        // Reset during an operation aborts it without a done pulse.
        start = 1; dividend = 1000; divisor = 3;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #2;
        d0 = n_done;
        rst_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quot", quot, 0);
        chk("midrst_rem", rem, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_done", n_done - d0, 0);
        chk("midrst_idle", busy, 0);
        op32(1000, 3);

        for (int i = 0; i < 1200; i++) op32($urandom, rand_divisor());

        op8(8'hFF, 8'h00);
        op8(8'hFF, 8'h01);
        op8(8'h00, 8'h07);
        op8(8'hFF, 8'hFF);
        for (int i = 0; i < 1500; i++) begin
            logic [W8-1:0] a8, b8;
            a8 = W8'($urandom);
            b8 = ($urandom_range(0, 15) == 0) ? '0 : W8'($urandom);
            op8(a8, b8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
